// File: rtl/serial_shift_tx.sv
// Parallel-to-serial transmitter: a holding register feeds a shift register so a
// queued word follows the previous one with no gap on the serial output.
module serial_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_rdy,
    output logic             dout,
    output logic             dout_vld,
    output logic             dout_last,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_hr;
    logic             r_hr_full;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_sr_act;
    logic             r_dout;
    logic             r_dout_vld;
    logic             r_dout_last;

    logic             w_load;
    logic             w_accept;
    logic             w_advance;
    logic [WIDTH-1:0] w_sr_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_hr_first;
    logic             w_next_bit;

    // The holding register may hand over its word on the same edge the final bit leaves.
    assign w_load     = r_hr_full && (!r_sr_act || (r_cnt == LAST_IDX));
    assign in_rdy     = !r_hr_full || w_load;
    assign w_accept   = in_vld && in_rdy && !clr;
    assign w_advance  = r_sr_act && (r_cnt != LAST_IDX);
    assign w_cnt_next = r_cnt + CW'(1);

    // Rotating keeps the bit being presented at the same end of the shift register.
    assign w_sr_next  = MSB_FIRST ? {r_sr[WIDTH-2:0], r_sr[WIDTH-1]}
                                  : {r_sr[0], r_sr[WIDTH-1:1]};
    assign w_hr_first = MSB_FIRST ? r_hr[WIDTH-1] : r_hr[0];
    assign w_next_bit = MSB_FIRST ? w_sr_next[WIDTH-1] : w_sr_next[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hr      <= '0;
            r_hr_full <= 1'b0;
        end else if (clr) begin
            r_hr_full <= 1'b0;
        end else if (w_accept) begin
            r_hr      <= in_data;
            r_hr_full <= 1'b1;
        end else if (w_load) begin
            r_hr_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_sr_act    <= 1'b0;
            r_dout      <= 1'b0;
            r_dout_vld  <= 1'b0;
            r_dout_last <= 1'b0;
        end else if (clr) begin
            r_cnt       <= '0;
            r_sr_act    <= 1'b0;
            r_dout      <= 1'b0;
            r_dout_vld  <= 1'b0;
            r_dout_last <= 1'b0;
        end else if (w_load) begin
            r_sr        <= r_hr;
            r_cnt       <= '0;
            r_sr_act    <= 1'b1;
            r_dout      <= w_hr_first;
            r_dout_vld  <= 1'b1;
            r_dout_last <= 1'b0;
        end else if (w_advance) begin
            r_sr        <= w_sr_next;
            r_cnt       <= w_cnt_next;
            r_dout      <= w_next_bit;
            r_dout_vld  <= 1'b1;
            r_dout_last <= (w_cnt_next == LAST_IDX);
        end else begin
            r_cnt       <= '0;
            r_sr_act    <= 1'b0;
            r_dout      <= 1'b0;
            r_dout_vld  <= 1'b0;
            r_dout_last <= 1'b0;
        end
    end

    assign dout      = r_dout;
    assign dout_vld  = r_dout_vld;
    assign dout_last = r_dout_last;
    assign busy      = r_hr_full || r_sr_act;

endmodule

// File: tb/tb_serial_shift_tx.sv
// Bench for serial_shift_tx: one MSB-first and one LSB-first instance, each with a
// bit scoreboard filled from known transmit-order constants and drained by a monitor.
module tb_serial_shift_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       clrM, inVldM, inRdyM, doutM, doutVldM, doutLastM, busyM;
    logic [7:0] inDataM;
    logic       clrL, inVldL, inRdyL, doutL, doutVldL, doutLastL, busyL;
    logic [7:0] inDataL;

    serial_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) uMsb (
        .clk(clk), .rst_n(rst_n), .clr(clrM), .in_vld(inVldM), .in_data(inDataM),
        .in_rdy(inRdyM), .dout(doutM), .dout_vld(doutVldM), .dout_last(doutLastM), .busy(busyM)
    );

    serial_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) uLsb (
        .clk(clk), .rst_n(rst_n), .clr(clrL), .in_vld(inVldL), .in_data(inDataL),
        .in_rdy(inRdyL), .dout(doutL), .dout_vld(doutVldL), .dout_last(doutLastL), .busy(busyL)
    );

    typedef struct { logic b; logic last; } bitT;
    typedef struct { bit lsb; logic [7:0] word; logic [7:0] seq; bit hold; } vecT;

    bitT qM[$];
    bitT qL[$];
    int  errors = 0;
    int  checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // seq holds the bits in transmit order, first bit in seq[7].
    task automatic pushSeq(input bit lsb, input logic [7:0] seq);
        for (int i = 7; i >= 0; i--) begin
            bitT e;
            e.b    = seq[i];
            e.last = (i == 0);
            if (lsb) qL.push_back(e);
            else     qM.push_back(e);
        end
    endtask

    task automatic setIn(input bit lsb, input logic v, input logic [7:0] d);
        if (lsb) begin inVldL = v; inDataL = d; end
        else     begin inVldM = v; inDataM = d; end
    endtask

    // Offers a word until accepted; while not ready, in_data is scrambled to show it is ignored.
    task automatic applyStimulus(input bit lsb, input logic [7:0] word, input logic [7:0] seq, input bit hold);
        int  n    = 0;
        bit  done = 0;
        logic rdy;
        setIn(lsb, 1'b1, word);
        while (!done && n < 100) begin
            @(negedge clk);
            rdy = lsb ? inRdyL : inRdyM;
            if (rdy) begin
                setIn(lsb, 1'b1, word);
                pushSeq(lsb, seq);
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                setIn(lsb, 1'b1, 8'($urandom));
                n++;
            end
        end
        checkOutput("acceptTimeout", 32'(done), 32'd1);
        if (!hold) setIn(lsb, 1'b0, 8'h00);
    endtask

    task automatic drainQueues();
        int n = 0;
        while ((qM.size() != 0 || qL.size() != 0 || busyM || busyL) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainTimeout", 32'(n < 200), 32'd1);
        checkOutput("drainMsbQueue", 32'(qM.size()), 32'd0);
        checkOutput("drainLsbQueue", 32'(qL.size()), 32'd0);
    endtask

    always @(negedge clk) begin : monMsb
        bitT e;
        if (doutVldM) begin
            if (qM.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL msbUnexpectedBit: got dout_vld=1 dout=%0b expected no bit", doutM);
            end else begin
                e = qM.pop_front();
                checkOutput("msbBit", 32'(doutM), 32'(e.b));
                checkOutput("msbLast", 32'(doutLastM), 32'(e.last));
            end
        end else begin
            checkOutput("msbIdleDout", 32'(doutM), 32'd0);
            checkOutput("msbIdleLast", 32'(doutLastM), 32'd0);
        end
    end

    always @(negedge clk) begin : monLsb
        bitT e;
        if (doutVldL) begin
            if (qL.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL lsbUnexpectedBit: got dout_vld=1 dout=%0b expected no bit", doutL);
            end else begin
                e = qL.pop_front();
                checkOutput("lsbBit", 32'(doutL), 32'(e.b));
                checkOutput("lsbLast", 32'(doutLastL), 32'(e.last));
            end
        end else begin
            checkOutput("lsbIdleDout", 32'(doutL), 32'd0);
            checkOutput("lsbIdleLast", 32'(doutLastL), 32'd0);
        end
    end

    initial begin
        #100000;
        errors++;
        checks++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        vecT vecs[8];
        int  vldSeen;

        vecs[0] = '{lsb: 1'b0, word: 8'hC3, seq: 8'hC3, hold: 1'b0};
        vecs[1] = '{lsb: 1'b1, word: 8'h01, seq: 8'h80, hold: 1'b0};
        vecs[2] = '{lsb: 1'b1, word: 8'hB4, seq: 8'h2D, hold: 1'b0};
        vecs[3] = '{lsb: 1'b0, word: 8'h12, seq: 8'h12, hold: 1'b1};
        vecs[4] = '{lsb: 1'b0, word: 8'h34, seq: 8'h34, hold: 1'b1};
        vecs[5] = '{lsb: 1'b0, word: 8'h56, seq: 8'h56, hold: 1'b0};
        vecs[6] = '{lsb: 1'b1, word: 8'hF0, seq: 8'h0F, hold: 1'b1};
        vecs[7] = '{lsb: 1'b1, word: 8'h6C, seq: 8'h36, hold: 1'b0};

        clrM = 0; inVldM = 0; inDataM = 0;
        clrL = 0; inVldL = 0; inDataL = 0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rstMsbRdy", 32'(inRdyM), 32'd1);
        checkOutput("rstMsbBusy", 32'(busyM), 32'd0);
        checkOutput("rstMsbVld", 32'(doutVldM), 32'd0);
        checkOutput("rstMsbDout", 32'(doutM), 32'd0);
        checkOutput("rstMsbLast", 32'(doutLastM), 32'd0);
        checkOutput("rstLsbRdy", 32'(inRdyL), 32'd1);
        checkOutput("rstLsbBusy", 32'(busyL), 32'd0);
        checkOutput("rstLsbVld", 32'(doutVldL), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // B4 then 0F with in_vld held: timing, ready window and no gap between words.
        @(negedge clk);
        checkOutput("aRdyIdle", 32'(inRdyM), 32'd1);
        inVldM = 1; inDataM = 8'hB4;
        pushSeq(0, 8'hB4);
        @(posedge clk);
        #1;
        inDataM = 8'h0F;
        pushSeq(0, 8'h0F);
        checkOutput("aNoEarlyBit", 32'(doutVldM), 32'd0);
        checkOutput("aRdyAfterAccept", 32'(inRdyM), 32'd1);
        checkOutput("aBusy", 32'(busyM), 32'd1);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) inVldM = 0;
            if (k <= 16) begin
                checkOutput($sformatf("aVld%0d", k), 32'(doutVldM), 32'd1);
                checkOutput($sformatf("aRdy%0d", k), 32'(inRdyM), 32'(k >= 8));
                checkOutput($sformatf("aLast%0d", k), 32'(doutLastM), 32'(k == 8 || k == 16));
            end else begin
                checkOutput("aIdleVld", 32'(doutVldM), 32'd0);
                checkOutput("aIdleBusy", 32'(busyM), 32'd0);
                checkOutput("aIdleRdy", 32'(inRdyM), 32'd1);
            end
        end

        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i].lsb, vecs[i].word, vecs[i].seq, vecs[i].hold);
        drainQueues();

        // Flush after the third bit of FF while AA waits in the holding register.
        @(negedge clk);
        inVldM = 1; inDataM = 8'hFF;
        pushSeq(0, 8'hFF);
        @(posedge clk);
        #1;
        inDataM = 8'hAA;
        @(posedge clk);
        #1;
        inVldM = 0;
        checkOutput("cHrFullRdy", 32'(inRdyM), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clrM = 1;
        @(posedge clk);
        #1;
        clrM = 0;
        qM.delete();
        checkOutput("cVld", 32'(doutVldM), 32'd0);
        checkOutput("cBusy", 32'(busyM), 32'd0);
        checkOutput("cRdy", 32'(inRdyM), 32'd1);
        vldSeen = 0;
        repeat (20) begin
            @(negedge clk);
            if (doutVldM) vldSeen++;
        end
        checkOutput("cNoAA", 32'(vldSeen), 32'd0);

        // Reset in the middle of 3C, with a word offered during reset.
        applyStimulus(0, 8'h3C, 8'h3C, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        qM.delete();
        #1;
        checkOutput("rVld", 32'(doutVldM), 32'd0);
        checkOutput("rDout", 32'(doutM), 32'd0);
        checkOutput("rBusy", 32'(busyM), 32'd0);
        checkOutput("rRdy", 32'(inRdyM), 32'd1);
        inVldM = 1; inDataM = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rNoAccept", 32'(busyM), 32'd0);
        inVldM = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rNoResumeVld", 32'(doutVldM), 32'd0);
        checkOutput("rNoResumeBusy", 32'(busyM), 32'd0);
        applyStimulus(0, 8'h81, 8'h81, 0);
        drainQueues();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_shift_tx.md
SERIAL_SHIFT_TX -- requirements
Module: serial_shift_tx

Interface
REQ-001 Parameter WIDTH, 8, word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, 1, bit order: 1 = MSB first, 0 = LSB first.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port clr  input  1  synchronous flush; discards buffered and in-flight words.
REQ-006 Port in_vld  input  1  parallel word valid.
REQ-007 Port in_data  input  WIDTH  parallel word.
REQ-008 Port in_rdy  output  1  block can accept a word this cycle.
REQ-009 Port dout  output  1  serial bit stream; drives the serial detector's din.
REQ-010 Port dout_vld  output  1  dout carries a valid data bit this cycle.
REQ-011 Port dout_last  output  1  dout carries the final bit of a word.
REQ-012 Port busy  output  1  holding register full or shifter active.

Function
REQ-013 Internal state SHALL be a WIDTH-bit holding register HR with flag hr_full, a WIDTH-bit shift register SR, a bit counter cnt (0..WIDTH-1) and a shifter-active flag sr_act.
REQ-014 Handshake: a word SHALL be accepted on a rising edge where in_vld=1 and in_rdy=1 and clr=0; in_data is written into HR and hr_full is set.
REQ-015 Define load = hr_full and (sr_act=0 or cnt=WIDTH-1); in_rdy SHALL equal (hr_full=0) or load, combinationally.
REQ-016 On an edge with load=1 (and clr=0), HR SHALL transfer to SR, cnt set to 0, sr_act set to 1; hr_full cleared unless a new word is accepted on the same edge, in which case HR takes the new word and hr_full stays 1.
REQ-017 dout, dout_vld, dout_last SHALL be registered outputs; the edge that loads SR SHALL also present the first bit (MSB if MSB_FIRST=1, else LSB) on dout with dout_vld=1.
REQ-018 Each subsequent edge with sr_act=1 and cnt<WIDTH-1 SHALL advance one bit, increment cnt; each bit is held exactly one clock.
REQ-019 dout_last SHALL be 1 exactly in the cycle the final bit is presented (cnt=WIDTH-1), else 0.
REQ-020 Latency: word accepted at edge E with shifter idle -> first bit visible after edge E+1, final bit after edge E+WIDTH.
REQ-021 Back-to-back: if HR is full when the final bit is shown, the next word's first bit SHALL follow on the very next edge with no gap; sustained throughput one word per WIDTH cycles.
REQ-022 After the final bit with hr_full=0, sr_act SHALL clear on the next edge; dout=0, dout_vld=0, dout_last=0 while idle.
REQ-023 clr=1 SHALL, on that edge, clear hr_full, sr_act, cnt, dout, dout_vld, dout_last; clr has priority over accept and load; in_rdy is 1 in the following cycle.
REQ-024 busy SHALL equal hr_full or sr_act.
REQ-025 in_data changes while in_vld=1 and in_rdy=0 SHALL have no effect; only the value at the accepting edge is transmitted.

Reset
REQ-026 rst_n low SHALL immediately clear hr_full, sr_act, cnt, SR, HR, dout, dout_vld, dout_last; busy=0, in_rdy=1 after release.
REQ-027 Reset mid-word SHALL abort transmission; no partial bits resume after release; first edge after release may accept a word.
REQ-028 No word SHALL be accepted while rst_n is low.

Verification
REQ-029 MSB_FIRST=1, WIDTH=8, accept 8'hB4 at edge E -> dout 1,0,1,1,0,1,0,0 after edges E+1..E+8, dout_vld=1 throughout, dout_last=1 only after E+8.
REQ-030 Accept 8'hB4 then 8'h0F (in_vld held) -> 0F bits 0,0,0,0,1,1,1,1 after edges E+9..E+16, no dout_vld gap; in_rdy=0 from E+2 until the cycle after E+7.
REQ-031 MSB_FIRST=0, accept 8'h01 -> dout 1,0,0,0,0,0,0,0; dout_last with final 0.
REQ-032 Three words offered continuously -> in_rdy low while HR full and cnt<7; all 24 bits emitted in order, none dropped or duplicated.
REQ-033 clr asserted after bit 3 of 8'hFF with HR holding 8'hAA -> dout_vld=0 next cycle, busy=0, 8'hAA never transmitted.
REQ-034 rst_n pulsed low mid-word -> outputs 0 immediately; after release, accepting 8'h81 yields 1,0,0,0,0,0,0,1 cleanly.
